// File: rtl/aq_gemac_rx_fifo.sv
// Frame-aware MAC receive FIFO: byte writer packs words, commits whole frames with a
// descriptor, and presents them first-word-fall-through. Option macro: AQ_GEMAC_RX_DROP_BAD_EN.
module aq_gemac_rx_fifo #(
  parameter int          RX_DEPTH   = 10,
  parameter int          BUFF_BYTES = 4,
  parameter int          DESC_DEPTH = 4,
  parameter logic [15:0] ERR_MASK   = 16'h00FF
) (
  input  logic                      MAC_CLK,
  input  logic                      RST_N,
  input  logic                      MAC_WE,
  input  logic                      MAC_START,
  input  logic [7:0]                MAC_DATA,
  input  logic                      MAC_END,
  input  logic [15:0]               MAC_STATUS,
  output logic                      MAC_FULL,
  input  logic                      BUFF_RE,
  output logic                      BUFF_VALID,
  output logic [8*BUFF_BYTES-1:0]   BUFF_DATA,
  output logic [BUFF_BYTES-1:0]     BUFF_BE,
  output logic                      BUFF_LAST,
  output logic                      BUFF_EMPTY,
  output logic                      FRAME_VALID,
  output logic [15:0]               FRAME_LENGTH,
  output logic [15:0]               FRAME_STATUS,
  output logic [DESC_DEPTH:0]       FRAME_COUNT,
  output logic [15:0]               DROP_COUNT
);

  localparam int LW = $clog2(BUFF_BYTES);
  localparam int DW = 8 * BUFF_BYTES;
  localparam int MW = 1 << RX_DEPTH;
  localparam int ND = 1 << DESC_DEPTH;
  localparam logic [RX_DEPTH:0] FULL_DIFF = {1'b1, {RX_DEPTH{1'b0}}};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_PREP, R_STREAM} rstate_t;

  wstate_t wstate, wstate_n;
  rstate_t rstate, rstate_n;

  logic [RX_DEPTH:0]   spec_ptr, spec_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, rd_ptr_n;
  logic [RX_DEPTH:0]   byte_ptr;
  logic [LW-1:0]       lane, lane_n, byte_idx;
  logic [DW-1:0]       lanes, lanes_n, byte_word;
  logic [15:0]         wr_len, wr_len_n;
  logic                mem_we;
  logic [RX_DEPTH-1:0] mem_waddr;
  logic [DW-1:0]       mem_wdata;
  logic [1:0]          drop_add;
  logic [16:0]         drop_sum;
  logic [15:0]         drop_cnt;
  logic                push, pop, acc, acc_start;
  logic                mem_full_spec, mem_full_commit, desc_full, frame_bad;

  logic [DW-1:0]       mem [MW];
  logic [DW-1:0]       mem_q;
  logic [31:0]         desc_mem [ND];
  logic [31:0]         desc_q;
  logic [DESC_DEPTH:0] desc_wr, desc_rd, desc_cnt;

  logic [15:0]         head_len, head_status, words_left, words_total;
  logic [16:0]         words_sum;
  logic [LW-1:0]       last_rem;
  logic [BUFF_BYTES-1:0] last_be;
  logic                rd_en;

`ifdef AQ_GEMAC_RX_DROP_BAD_EN
  assign frame_bad = |(MAC_STATUS & ERR_MASK);
`else
  logic unused_err_mask;
  assign frame_bad       = 1'b0;
  assign unused_err_mask = ^ERR_MASK;
`endif

  // Fullness is judged against the read pointer, so words free up as they are consumed.
  assign mem_full_spec   = (spec_ptr ^ rd_ptr) == FULL_DIFF;
  assign mem_full_commit = (commit_ptr ^ rd_ptr) == FULL_DIFF;
  assign desc_cnt        = desc_wr - desc_rd;
  assign desc_full       = desc_cnt[DESC_DEPTH];
  assign MAC_FULL        = mem_full_spec || desc_full;

  always_comb begin
    wstate_n     = wstate;
    spec_ptr_n   = spec_ptr;
    commit_ptr_n = commit_ptr;
    lane_n       = lane;
    lanes_n      = lanes;
    wr_len_n     = wr_len;
    mem_we       = 1'b0;
    mem_waddr    = spec_ptr[RX_DEPTH-1:0];
    mem_wdata    = lanes;
    drop_add     = 2'd0;
    push         = 1'b0;
    acc          = 1'b0;
    acc_start    = 1'b0;
    byte_idx     = '0;
    byte_ptr     = spec_ptr;
    byte_word    = '0;
    case (wstate)
      W_IDLE: begin
        if (MAC_WE && MAC_START) begin
          if (MAC_FULL) begin
            wstate_n = W_DROP;
            drop_add = 2'd1;
          end else begin
            acc       = 1'b1;
            acc_start = 1'b1;
          end
        end
      end
      W_DATA: begin
        if (MAC_END) begin
          wstate_n = W_IDLE;
          lane_n   = '0;
          lanes_n  = '0;
          if (frame_bad || (lane != '0 && mem_full_spec)) begin
            spec_ptr_n = commit_ptr;
            drop_add   = 2'd1;
          end else begin
            push = 1'b1;
            if (lane != '0) begin
              mem_we       = 1'b1;
              spec_ptr_n   = spec_ptr + 1'b1;
              commit_ptr_n = spec_ptr + 1'b1;
            end else begin
              commit_ptr_n = spec_ptr;
            end
          end
        end else if (MAC_WE && MAC_START) begin
          // Restart without END: the open frame is lost, the new byte opens a fresh one.
          drop_add   = 2'd1;
          spec_ptr_n = commit_ptr;
          if (mem_full_commit || desc_full) begin
            wstate_n = W_DROP;
            drop_add = 2'd2;
            lane_n   = '0;
            lanes_n  = '0;
          end else begin
            acc       = 1'b1;
            acc_start = 1'b1;
          end
        end else if (MAC_WE) begin
          acc = 1'b1;
        end
      end
      W_DROP: begin
        if (MAC_END) wstate_n = W_IDLE;
      end
      default: wstate_n = W_IDLE;
    endcase

    if (acc) begin
      byte_idx  = acc_start ? '0 : lane;
      byte_ptr  = acc_start ? commit_ptr : spec_ptr;
      byte_word = acc_start ? '0 : lanes;
      byte_word[byte_idx*8 +: 8] = MAC_DATA;
      wr_len_n  = acc_start ? 16'd1 : wr_len + 16'd1;
      wstate_n  = W_DATA;
      if (byte_idx == LW'(BUFF_BYTES - 1)) begin
        lane_n  = '0;
        lanes_n = '0;
        if (!acc_start && mem_full_spec) begin
          wstate_n   = W_DROP;
          spec_ptr_n = commit_ptr;
          drop_add   = 2'd1;
        end else begin
          mem_we     = 1'b1;
          mem_waddr  = byte_ptr[RX_DEPTH-1:0];
          mem_wdata  = byte_word;
          spec_ptr_n = byte_ptr + 1'b1;
        end
      end else begin
        lane_n     = byte_idx + LW'(1);
        lanes_n    = byte_word;
        spec_ptr_n = byte_ptr;
      end
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_add};

  always_ff @(posedge MAC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wstate     <= W_IDLE;
      spec_ptr   <= '0;
      commit_ptr <= '0;
      lane       <= '0;
      lanes      <= '0;
      wr_len     <= '0;
      drop_cnt   <= '0;
      desc_wr    <= '0;
    end else begin
      wstate     <= wstate_n;
      spec_ptr   <= spec_ptr_n;
      commit_ptr <= commit_ptr_n;
      lane       <= lane_n;
      lanes      <= lanes_n;
      wr_len     <= wr_len_n;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      if (push) desc_wr <= desc_wr + (DESC_DEPTH+1)'(1);
    end
  end

  always_ff @(posedge MAC_CLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (push) desc_mem[desc_wr[DESC_DEPTH-1:0]] <= {wr_len, MAC_STATUS};
  end

  assign rd_en    = BUFF_RE && BUFF_VALID;
  assign pop      = rd_en && (words_left == 16'd1);
  assign rd_ptr_n = rd_ptr + {{RX_DEPTH{1'b0}}, rd_en};

  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE:   if (desc_cnt != '0) rstate_n = R_LOAD;
      R_LOAD:   rstate_n = R_PREP;
      R_PREP:   rstate_n = R_STREAM;
      R_STREAM: if (pop) rstate_n = R_IDLE;
      default:  rstate_n = R_IDLE;
    endcase
  end

  assign words_sum   = {1'b0, head_len} + 17'(BUFF_BYTES - 1);
  assign words_total = 16'(words_sum >> LW);
  assign last_rem    = head_len[LW-1:0] - LW'(1);

  always_comb begin
    last_be = '0;
    for (int i = 0; i < BUFF_BYTES; i++) last_be[i] = (i <= int'(last_rem));
  end

  // mem_q always tracks the word at the next read pointer, giving fall-through at full rate.
  always_ff @(posedge MAC_CLK or negedge RST_N) begin
    if (!RST_N) begin
      rstate      <= R_IDLE;
      rd_ptr      <= '0;
      desc_rd     <= '0;
      head_len    <= '0;
      head_status <= '0;
      words_left  <= '0;
      mem_q       <= '0;
      desc_q      <= '0;
    end else begin
      rstate <= rstate_n;
      rd_ptr <= rd_ptr_n;
      mem_q  <= mem[rd_ptr_n[RX_DEPTH-1:0]];
      desc_q <= desc_mem[desc_rd[DESC_DEPTH-1:0]];
      if (rstate == R_LOAD) begin
        head_len    <= desc_q[31:16];
        head_status <= desc_q[15:0];
      end
      if (rstate == R_PREP) words_left <= words_total;
      else if (rd_en) words_left <= words_left - 16'd1;
      if (pop) desc_rd <= desc_rd + (DESC_DEPTH+1)'(1);
    end
  end

  assign BUFF_VALID   = (rstate == R_STREAM);
  assign FRAME_VALID  = BUFF_VALID;
  assign BUFF_LAST    = BUFF_VALID && (words_left == 16'd1);
  assign BUFF_DATA    = BUFF_VALID ? mem_q : '0;
  assign BUFF_BE      = !BUFF_VALID ? '0 : (BUFF_LAST ? last_be : {BUFF_BYTES{1'b1}});
  assign FRAME_LENGTH = BUFF_VALID ? head_len : 16'd0;
  assign FRAME_STATUS = BUFF_VALID ? head_status : 16'd0;
  assign FRAME_COUNT  = desc_cnt;
  assign BUFF_EMPTY   = (desc_cnt == '0);
  assign DROP_COUNT   = drop_cnt;

endmodule

// File: tb/tb_aq_gemac_rx_fifo.sv
// Directed bench for aq_gemac_rx_fifo on a 64-word memory: framing, byte enables,
// latency, overflow drop, restart, bad-status handling, pointer wrap and mid-frame reset.
module tb_aq_gemac_rx_fifo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mac_we = 1'b0, mac_start = 1'b0, mac_end = 1'b0;
  logic [7:0]  mac_data = 8'd0;
  logic [15:0] mac_status = 16'd0;
  logic        mac_full;
  logic        buff_re = 1'b0;
  logic        buff_valid, buff_last, buff_empty, frame_valid;
  logic [31:0] buff_data;
  logic [3:0]  buff_be;
  logic [15:0] frame_length, frame_status, drop_count;
  logic [4:0]  frame_count;

  int total = 0;
  int bad = 0;
  int exp_drop = 0;

  aq_gemac_rx_fifo #(.RX_DEPTH(6), .BUFF_BYTES(4), .DESC_DEPTH(4), .ERR_MASK(16'h00FF)) dut (
    .MAC_CLK(clk), .RST_N(rst_n), .MAC_WE(mac_we), .MAC_START(mac_start), .MAC_DATA(mac_data),
    .MAC_END(mac_end), .MAC_STATUS(mac_status), .MAC_FULL(mac_full), .BUFF_RE(buff_re),
    .BUFF_VALID(buff_valid), .BUFF_DATA(buff_data), .BUFF_BE(buff_be), .BUFF_LAST(buff_last),
    .BUFF_EMPTY(buff_empty), .FRAME_VALID(frame_valid), .FRAME_LENGTH(frame_length),
    .FRAME_STATUS(frame_status), .FRAME_COUNT(frame_count), .DROP_COUNT(drop_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bytes(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      mac_we = 1'b1; mac_start = (i == 0); mac_data = 8'(base + i);
      tick();
    end
    mac_we = 1'b0; mac_start = 1'b0;
  endtask

  task automatic send_end(input logic [15:0] st);
    mac_end = 1'b1; mac_status = st;
    tick();
    mac_end = 1'b0; mac_status = 16'd0;
  endtask

  task automatic read_frame(input string name, input int len, input int base, input logic [15:0] st);
    int nw, waited;
    logic [31:0] exp_word, mask;
    logic [3:0]  exp_be;
    nw = (len + 3) / 4;
    waited = 0;
    while (frame_valid !== 1'b1 && waited < 400) begin tick(); waited++; end
    total++;
    if (frame_valid !== 1'b1) begin
      bad++; $display("FAIL %s wait frame_valid got=%b want=1", name, frame_valid);
      return;
    end
    for (int w = 0; w < nw; w++) begin
      exp_be = (w == nw - 1) ? 4'((1 << (((len - 1) % 4) + 1)) - 1) : 4'hF;
      exp_word = 32'd0; mask = 32'd0;
      for (int l = 0; l < 4; l++) if (exp_be[l]) begin
        exp_word[l*8 +: 8] = 8'(base + w*4 + l);
        mask[l*8 +: 8] = 8'hFF;
      end
      total++; if (buff_valid !== 1'b1) begin bad++; $display("FAIL %s valid w%0d got=%b want=1", name, w, buff_valid); end
      total++; if ((buff_data & mask) !== exp_word) begin bad++; $display("FAIL %s data w%0d got=%h want=%h", name, w, buff_data & mask, exp_word); end
      total++; if (buff_be !== exp_be) begin bad++; $display("FAIL %s be w%0d got=%b want=%b", name, w, buff_be, exp_be); end
      total++; if (buff_last !== (w == nw - 1)) begin bad++; $display("FAIL %s last w%0d got=%b", name, w, buff_last); end
      total++; if (frame_length !== 16'(len)) begin bad++; $display("FAIL %s length w%0d got=%0d want=%0d", name, w, frame_length, len); end
      total++; if (frame_status !== st) begin bad++; $display("FAIL %s status w%0d got=%h want=%h", name, w, frame_status, st); end
      buff_re = 1'b1;
      tick();
    end
    buff_re = 1'b0;
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL %s gap frame_valid got=%b want=0", name, frame_valid); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (buff_empty !== 1'b1) begin bad++; $display("FAIL reset empty got=%b want=1", buff_empty); end
    total++; if (frame_count !== 5'd0) begin bad++; $display("FAIL reset count got=%0d want=0", frame_count); end
    total++; if ({frame_valid, buff_valid, mac_full, buff_last} !== 4'b0) begin bad++; $display("FAIL reset flags got=%b want=0000", {frame_valid, buff_valid, mac_full, buff_last}); end
    total++; if ({buff_data, buff_be, drop_count, frame_length, frame_status} !== '0) begin bad++; $display("FAIL reset buses nonzero"); end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    send_bytes(8, 8'hA0);
    send_end(16'h0005);
    total++; if (frame_count !== 5'd1 || buff_empty !== 1'b0) begin bad++; $display("FAIL latency count got=%0d empty=%b want=1/0", frame_count, buff_empty); end
    tick(); tick();
    total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL latency early got=%b want=0", frame_valid); end
    tick();
    total++; if (frame_valid !== 1'b1 || buff_valid !== 1'b1) begin bad++; $display("FAIL latency on got=%b%b want=11", frame_valid, buff_valid); end
    read_frame("lat8", 8, 8'hA0, 16'h0005);
  endtask

  task automatic test_frame64();
    send_bytes(64, 0); send_end(16'h0100);
    read_frame("f64", 64, 0, 16'h0100);
  endtask

  task automatic test_frame61();
    send_bytes(61, 8'h20); send_end(16'h0101);
    read_frame("f61", 61, 8'h20, 16'h0101);
    total++; if (buff_empty !== 1'b1) begin bad++; $display("FAIL f61 empty got=%b want=1", buff_empty); end
  endtask

  task automatic test_full();
    for (int f = 0; f < 4; f++) begin
      total++; if (mac_full !== 1'b0) begin bad++; $display("FAIL full early f%0d got=%b want=0", f, mac_full); end
      send_bytes(64, f * 8'h11); send_end(16'(f));
    end
    total++; if (mac_full !== 1'b1) begin bad++; $display("FAIL full flag got=%b want=1", mac_full); end
    total++; if (frame_count !== 5'd4) begin bad++; $display("FAIL full count got=%0d want=4", frame_count); end
    send_bytes(64, 8'h44); send_end(16'h0009);
    exp_drop++;
    total++; if (drop_count !== 16'(exp_drop)) begin bad++; $display("FAIL full drop got=%0d want=%0d", drop_count, exp_drop); end
    for (int f = 0; f < 4; f++) read_frame("full", 64, f * 8'h11, 16'(f));
    total++; if (frame_count !== 5'd0 || mac_full !== 1'b0) begin bad++; $display("FAIL full after got=%0d/%b want=0/0", frame_count, mac_full); end
  endtask

  task automatic test_restart();
    send_bytes(10, 8'h40);
    send_bytes(12, 8'h80);
    send_end(16'h0033);
    exp_drop++;
    total++; if (drop_count !== 16'(exp_drop)) begin bad++; $display("FAIL restart drop got=%0d want=%0d", drop_count, exp_drop); end
    total++; if (frame_count !== 5'd1) begin bad++; $display("FAIL restart count got=%0d want=1", frame_count); end
    read_frame("restart", 12, 8'h80, 16'h0033);
  endtask

  task automatic test_bad_status();
    send_bytes(20, 8'h10); send_end(16'h0001);
    send_bytes(9, 8'h20); send_end(16'h0200);
`ifdef AQ_GEMAC_RX_DROP_BAD_EN
    exp_drop++;
    total++; if (frame_count !== 5'd1) begin bad++; $display("FAIL badst count got=%0d want=1", frame_count); end
`else
    total++; if (frame_count !== 5'd2) begin bad++; $display("FAIL badst count got=%0d want=2", frame_count); end
    read_frame("badst_err", 20, 8'h10, 16'h0001);
`endif
    read_frame("badst_good", 9, 8'h20, 16'h0200);
    total++; if (drop_count !== 16'(exp_drop)) begin bad++; $display("FAIL badst drop got=%0d want=%0d", drop_count, exp_drop); end
  endtask

  task automatic test_overflow();
    send_bytes(300, 8'h00); send_end(16'h0000);
    exp_drop++;
    total++; if (drop_count !== 16'(exp_drop)) begin bad++; $display("FAIL ovf drop got=%0d want=%0d", drop_count, exp_drop); end
    total++; if (frame_count !== 5'd0 || mac_full !== 1'b0) begin bad++; $display("FAIL ovf state got=%0d/%b want=0/0", frame_count, mac_full); end
    send_bytes(40, 8'h55); send_end(16'h0077);
    read_frame("ovf_next", 40, 8'h55, 16'h0077);
  endtask

  task automatic test_wrap();
    fork
      begin
        for (int f = 0; f < 40; f++) begin send_bytes(100, f * 7); send_end(16'(f + 16'h1000)); end
      end
      begin
        for (int f = 0; f < 40; f++) read_frame("wrap", 100, f * 7, 16'(f + 16'h1000));
      end
    join
    tick();
    total++; if (frame_count !== 5'd0) begin bad++; $display("FAIL wrap count got=%0d want=0", frame_count); end
    total++; if (drop_count !== 16'(exp_drop)) begin bad++; $display("FAIL wrap drop got=%0d want=%0d", drop_count, exp_drop); end
  endtask

  task automatic test_reset_midframe();
    send_bytes(8, 8'h70); send_end(16'h0011);
    send_bytes(10, 8'h60);
    total++; if (frame_count !== 5'd1) begin bad++; $display("FAIL rstmid pre got=%0d want=1", frame_count); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (buff_empty !== 1'b1 || frame_count !== 5'd0) begin bad++; $display("FAIL rstmid now empty=%b count=%0d want=1/0", buff_empty, frame_count); end
    total++; if (drop_count !== 16'd0 || frame_valid !== 1'b0) begin bad++; $display("FAIL rstmid drop=%0d fv=%b want=0/0", drop_count, frame_valid); end
    exp_drop = 0;
    @(negedge clk); rst_n = 1'b1;
    tick();
    send_bytes(16, 8'h90); send_end(16'h0042);
    read_frame("rstmid_next", 16, 8'h90, 16'h0042);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_frame64();
    test_frame61();
    test_full();
    test_restart();
    test_bad_status();
    test_overflow();
    test_wrap();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
